// File: rtl/ram_pkg.sv
// Shared RAM command types and data-path widths for the ram block and its arbiter.
package ram_pkg;

  localparam int unsigned ADDRW      = 17;
  localparam int unsigned QUAD_WIDTH = 64;
  localparam int unsigned LONG_WIDTH = 32;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_LOAD  = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2,
    RAM_QUAD = 2'd3
  } ram_size_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the fetch port, data port and RAM-side port of ram_arbiter.
// slave: the arbiter's view. master: requesters plus the RAM.
interface ram_arbiter_if;
  import ram_pkg::*;

  // fetch port
  logic                  i_req;
  logic [ADDRW-1:0]      i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [LONG_WIDTH-1:0] i_rdata;
  logic                  i_err;

  // data port
  logic                  d_req;
  ram_op_t               d_op;
  ram_size_t             d_size;
  logic [ADDRW-1:0]      d_addr;
  logic [QUAD_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [QUAD_WIDTH-1:0] d_rdata;
  logic                  d_err;

  // RAM side
  ram_op_t               ram_op;
  ram_size_t             ram_size;
  logic [ADDRW-1:0]      ram_addr;
  logic [QUAD_WIDTH-1:0] ram_data_in;
  logic [QUAD_WIDTH-1:0] ram_data_out;

  logic                  busy;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    input  d_req, d_op, d_size, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_op, ram_size, ram_addr, ram_data_in,
    input  ram_data_out,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    output d_req, d_op, d_size, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_op, ram_size, ram_addr, ram_data_in,
    output ram_data_out,
    input  busy
  );

endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer sharing the single 64-bit RAM port between
// instruction fetch (long loads) and the data port (all sizes, load/store).
// One RAM op per grant; response registered two cycles after the grant.
// Misaligned accesses get an error response without touching the RAM.
// Optional: define RAM_ARB_RR_EN for round-robin arbitration instead of
// fixed data-port priority.
module ram_arbiter
  import ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_n;
  logic                  owner_d;      // 1: data port owns the in-flight op
  logic                  owner_d_n;
  logic                  owner_st;     // in-flight data op is a store
  logic                  owner_st_n;

  logic                  i_rvalid_n;
  logic                  i_err_n;
  logic [LONG_WIDTH-1:0] i_rdata_n;
  logic                  d_rvalid_n;
  logic                  d_err_n;
  logic [QUAD_WIDTH-1:0] d_rdata_n;

  logic                  d_elig;
  logic                  pick_d;
  logic                  d_aligned;
  logic                  i_aligned;

  // Natural alignment check on the low address bits.
  function automatic logic is_aligned(input ram_size_t size, input logic [2:0] lo);
    logic ok;
    case (size)
      RAM_QUAD: ok = (lo == 3'b000);
      RAM_LONG: ok = (lo[1:0] == 2'b00);
      RAM_WORD: ok = (lo[0] == 1'b0);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign d_elig    = bus.d_req && ((bus.d_op == RAM_LOAD) || (bus.d_op == RAM_STORE));
  assign d_aligned = is_aligned(bus.d_size, bus.d_addr[2:0]);
  assign i_aligned = is_aligned(RAM_LONG, bus.i_addr[2:0]);
  assign bus.busy  = (state == S_WAIT);

`ifdef RAM_ARB_RR_EN
  logic last_d;  // 1: data port won the most recent grant

  // Track the last winner, misaligned grants included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (bus.i_gnt || bus.d_gnt) begin
      last_d <= bus.d_gnt;
    end
  end

  assign pick_d = d_elig && !(bus.i_req && last_d);
`else
  assign pick_d = d_elig;
`endif

  // State, ownership and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      owner_d      <= 1'b0;
      owner_st     <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.i_err    <= 1'b0;
      bus.i_rdata  <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.d_rdata  <= '0;
    end else begin
      state        <= state_n;
      owner_d      <= owner_d_n;
      owner_st     <= owner_st_n;
      bus.i_rvalid <= i_rvalid_n;
      bus.i_err    <= i_err_n;
      bus.i_rdata  <= i_rdata_n;
      bus.d_rvalid <= d_rvalid_n;
      bus.d_err    <= d_err_n;
      bus.d_rdata  <= d_rdata_n;
    end
  end

  // Arbitration, RAM command drive and next response.
  always_comb begin
    state_n         = state;
    owner_d_n       = owner_d;
    owner_st_n      = owner_st;
    bus.i_gnt       = 1'b0;
    bus.d_gnt       = 1'b0;
    bus.ram_op      = RAM_NOP;
    bus.ram_size    = RAM_BYTE;
    bus.ram_addr    = '0;
    bus.ram_data_in = '0;
    i_rvalid_n      = 1'b0;
    i_err_n         = 1'b0;
    i_rdata_n       = '0;
    d_rvalid_n      = 1'b0;
    d_err_n         = 1'b0;
    d_rdata_n       = '0;

    case (state)
      S_IDLE: begin
        if (!rst) begin
          if (pick_d) begin
            bus.d_gnt  = 1'b1;
            owner_d_n  = 1'b1;
            owner_st_n = (bus.d_op == RAM_STORE);
            if (d_aligned) begin
              bus.ram_op      = bus.d_op;
              bus.ram_size    = bus.d_size;
              bus.ram_addr    = bus.d_addr;
              bus.ram_data_in = bus.d_wdata;
              state_n         = S_WAIT;
            end else begin
              d_rvalid_n = 1'b1;
              d_err_n    = 1'b1;
            end
          end else if (bus.i_req) begin
            bus.i_gnt  = 1'b1;
            owner_d_n  = 1'b0;
            owner_st_n = 1'b0;
            if (i_aligned) begin
              bus.ram_op   = RAM_LOAD;
              bus.ram_size = RAM_LONG;
              bus.ram_addr = bus.i_addr;
              state_n      = S_WAIT;
            end else begin
              i_rvalid_n = 1'b1;
              i_err_n    = 1'b1;
            end
          end
        end
      end

      S_WAIT: begin
        // RAM output reflects the address registered at the grant edge.
        state_n = S_IDLE;
        if (owner_d) begin
          d_rvalid_n = 1'b1;
          d_rdata_n  = owner_st ? '0 : bus.ram_data_out;
        end else begin
          i_rvalid_n = 1'b1;
          i_rdata_n  = bus.ram_data_out[LONG_WIDTH-1:0];
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a little-endian byte RAM model
// (one-cycle read latency, address registered on any non-NOP op).
module tb_ram_arbiter;
  import ram_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [0:511];
  logic [8:0] ra;
  ram_size_t  rs;

  function automatic int nbytes(input ram_size_t s);
    case (s)
      RAM_QUAD: return 8;
      RAM_LONG: return 4;
      RAM_WORD: return 2;
      default:  return 1;
    endcase
  endfunction

  // Latch address on any op; write store bytes.
  always @(posedge clk) begin
    if (bus.ram_op != RAM_NOP) begin
      ra <= bus.ram_addr[8:0];
      rs <= bus.ram_size;
      if (bus.ram_op == RAM_STORE) begin
        for (int k = 0; k < 8; k++) begin
          if (k < nbytes(bus.ram_size)) begin
            mem[9'(bus.ram_addr[8:0] + 9'(k))] <= bus.ram_data_in[8*k +: 8];
          end
        end
      end
    end
  end

  // Zero-extended read from the latched address.
  always_comb begin
    bus.ram_data_out = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < nbytes(rs)) begin
        bus.ram_data_out[8*k +: 8] = mem[9'(ra + 9'(k))];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single aligned store through the data port, checked end to end.
  task automatic store(input ram_size_t size, input logic [16:0] addr, input logic [63:0] data);
    tick();
    bus.d_req   = 1'b1;
    bus.d_op    = RAM_STORE;
    bus.d_size  = size;
    bus.d_addr  = addr;
    bus.d_wdata = data;
    #1;
    chk("pre_gnt", 64'(bus.d_gnt), 64'd1);
    chk("pre_op", 64'(bus.ram_op), 64'(RAM_STORE));
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("pre_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("pre_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("pre_rdata", bus.d_rdata, 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_op    = RAM_NOP;
    bus.d_size  = RAM_BYTE;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    ra = '0;
    rs = RAM_BYTE;

    // Reset state
    #2;
    chk("rst_i_gnt", 64'(bus.i_gnt), 64'd0);
    chk("rst_d_gnt", 64'(bus.d_gnt), 64'd0);
    chk("rst_i_rvalid", 64'(bus.i_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    chk("rst_ram_op", 64'(bus.ram_op), 64'(RAM_NOP));
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    tick();
    rst = 1'b0;

    // Preload RAM
    store(RAM_QUAD, 17'h00010, 64'h0);
    store(RAM_LONG, 17'h00104, 64'hDEADBEEF);

    // Store byte then load quad, back to back
    tick();
    bus.d_req   = 1'b1;
    bus.d_op    = RAM_STORE;
    bus.d_size  = RAM_BYTE;
    bus.d_addr  = 17'h00013;
    bus.d_wdata = 64'hA5;
    #1;
    chk("sb_gnt", 64'(bus.d_gnt), 64'd1);
    chk("sb_op", 64'(bus.ram_op), 64'(RAM_STORE));
    chk("sb_size", 64'(bus.ram_size), 64'(RAM_BYTE));
    chk("sb_addr", 64'(bus.ram_addr), 64'h13);
    chk("sb_wdata", bus.ram_data_in, 64'hA5);
    tick();
    bus.d_op   = RAM_LOAD;
    bus.d_size = RAM_QUAD;
    bus.d_addr = 17'h00010;
    #1;
    chk("lq_wait_gnt", 64'(bus.d_gnt), 64'd0);
    chk("lq_wait_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("sb_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("sb_rdata", bus.d_rdata, 64'd0);
    chk("lq_gnt", 64'(bus.d_gnt), 64'd1);
    chk("lq_op", 64'(bus.ram_op), 64'(RAM_LOAD));
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("lq_rvalid_early", 64'(bus.d_rvalid), 64'd0);
    tick();
    chk("lq_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("lq_rdata", bus.d_rdata, 64'h00000000_A5000000);

    // Fetch alone
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 17'h00104;
    #1;
    chk("f_gnt", 64'(bus.i_gnt), 64'd1);
    chk("f_op", 64'(bus.ram_op), 64'(RAM_LOAD));
    chk("f_size", 64'(bus.ram_size), 64'(RAM_LONG));
    chk("f_addr", 64'(bus.ram_addr), 64'h104);
    tick();
    bus.i_req = 1'b0;
    #1;
    chk("f_busy", 64'(bus.busy), 64'd1);
    chk("f_wait_op", 64'(bus.ram_op), 64'(RAM_NOP));
    tick();
    chk("f_rvalid", 64'(bus.i_rvalid), 64'd1);
    chk("f_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
    chk("f_err", 64'(bus.i_err), 64'd0);
    chk("f_no_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    tick();
    chk("f_rvalid_pulse", 64'(bus.i_rvalid), 64'd0);

    // Conflict, data drops after its grant
    bus.i_req  = 1'b1;
    bus.i_addr = 17'h00104;
    bus.d_req  = 1'b1;
    bus.d_op   = RAM_LOAD;
    bus.d_size = RAM_LONG;
    bus.d_addr = 17'h00104;
    #1;
    chk("c1_d_gnt", 64'(bus.d_gnt), 64'd1);
    chk("c1_i_gnt", 64'(bus.i_gnt), 64'd0);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("c1_wait_i_gnt", 64'(bus.i_gnt), 64'd0);
    tick();
    chk("c1_i_gnt2", 64'(bus.i_gnt), 64'd1);
    chk("c1_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("c1_d_rdata", bus.d_rdata, 64'hDEADBEEF);
    tick();
    bus.i_req = 1'b0;
    tick();
    chk("c1_i_rvalid", 64'(bus.i_rvalid), 64'd1);
    chk("c1_i_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);

    // Conflict, both requests held for three grants
    tick();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    #1;
    chk("c2_g0_d", 64'(bus.d_gnt), 64'd1);
    chk("c2_g0_i", 64'(bus.i_gnt), 64'd0);
    tick();
    tick();
    chk("c2_r0_d", 64'(bus.d_rvalid), 64'd1);
`ifdef RAM_ARB_RR_EN
    chk("c2_g1_d", 64'(bus.d_gnt), 64'd0);
    chk("c2_g1_i", 64'(bus.i_gnt), 64'd1);
`else
    chk("c2_g1_d", 64'(bus.d_gnt), 64'd1);
    chk("c2_g1_i", 64'(bus.i_gnt), 64'd0);
`endif
    tick();
    tick();
    chk("c2_g2_d", 64'(bus.d_gnt), 64'd1);
    chk("c2_g2_i", 64'(bus.i_gnt), 64'd0);
`ifdef RAM_ARB_RR_EN
    chk("c2_r1_i", 64'(bus.i_rvalid), 64'd1);
`else
    chk("c2_r1_d", 64'(bus.d_rvalid), 64'd1);
`endif
    tick();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk("c2_r2_d", 64'(bus.d_rvalid), 64'd1);
    chk("c2_r2_rdata", bus.d_rdata, 64'hDEADBEEF);
    chk("c2_r2_no_i", 64'(bus.i_rvalid), 64'd0);

    // Misaligned data load
    tick();
    bus.d_req  = 1'b1;
    bus.d_op   = RAM_LOAD;
    bus.d_size = RAM_LONG;
    bus.d_addr = 17'h00006;
    #1;
    chk("ma_d_gnt", 64'(bus.d_gnt), 64'd1);
    chk("ma_d_op", 64'(bus.ram_op), 64'(RAM_NOP));
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("ma_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("ma_d_err", 64'(bus.d_err), 64'd1);
    chk("ma_d_rdata", bus.d_rdata, 64'd0);
    chk("ma_d_busy", 64'(bus.busy), 64'd0);

    // Misaligned fetch
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 17'h00102;
    #1;
    chk("ma_i_gnt", 64'(bus.i_gnt), 64'd1);
    chk("ma_i_op", 64'(bus.ram_op), 64'(RAM_NOP));
    tick();
    bus.i_req = 1'b0;
    #1;
    chk("ma_i_rvalid", 64'(bus.i_rvalid), 64'd1);
    chk("ma_i_err", 64'(bus.i_err), 64'd1);
    chk("ma_i_rdata", 64'(bus.i_rdata), 64'd0);

    // Data request with NOP op is ignored
    tick();
    bus.d_req  = 1'b1;
    bus.d_op   = RAM_NOP;
    bus.i_req  = 1'b1;
    bus.i_addr = 17'h00104;
    #1;
    chk("nop_d_gnt", 64'(bus.d_gnt), 64'd0);
    chk("nop_i_gnt", 64'(bus.i_gnt), 64'd1);
    tick();
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    tick();
    chk("nop_i_rvalid", 64'(bus.i_rvalid), 64'd1);
    chk("nop_i_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
    chk("nop_d_rvalid", 64'(bus.d_rvalid), 64'd0);

    // Reset during S_WAIT
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 17'h00104;
    #1;
    chk("rw_gnt", 64'(bus.i_gnt), 64'd1);
    tick();
    bus.i_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rw_busy", 64'(bus.busy), 64'd0);
    chk("rw_i_rvalid0", 64'(bus.i_rvalid), 64'd0);
    chk("rw_ram_op", 64'(bus.ram_op), 64'(RAM_NOP));
    tick();
    chk("rw_i_rvalid1", 64'(bus.i_rvalid), 64'd0);
    chk("rw_i_rdata", 64'(bus.i_rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("rw_i_rvalid2", 64'(bus.i_rvalid), 64'd0);
    bus.i_req = 1'b1;
    #1;
    chk("rw_next_gnt", 64'(bus.i_gnt), 64'd1);
    tick();
    bus.i_req = 1'b0;
    tick();
    chk("rw_next_rvalid", 64'(bus.i_rvalid), 64'd1);
    chk("rw_next_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 64-bit byte-addressable ram block (4x SPRAM, 17-bit byte address).
- Shares the single RAM port between the instruction-fetch port (i_*, 32-bit long loads only) and the data port (d_*, byte/word/long/quad loads and stores).
- Issues one RAM operation per grant, collects the one-cycle-latency read data, and returns a registered response.
- Rejects misaligned accesses with an error response and performs no RAM access for them.

Parameters:
ADDRW, 17, byte address width (matches ram)
QUAD_WIDTH, 64, data path width
LONG_WIDTH, 32, fetch data width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_req  input  1  fetch request, held until i_gnt
i_addr  input  ADDRW  fetch byte address
i_gnt  output  1  one-cycle pulse, fetch request accepted
i_rvalid  output  1  one-cycle pulse, fetch response valid
i_rdata  output  LONG_WIDTH  fetched long, valid with i_rvalid
i_err  output  1  misaligned fetch, valid with i_rvalid
d_req  input  1  data request, held until d_gnt
d_op  input  ram_pkg::ram_op_t  RAM_LOAD or RAM_STORE
d_size  input  ram_pkg::ram_size_t  access size
d_addr  input  ADDRW  data byte address
d_wdata  input  QUAD_WIDTH  store data, right-aligned
d_gnt  output  1  one-cycle pulse, data request accepted
d_rvalid  output  1  one-cycle pulse, data response (load data or store done)
d_rdata  output  QUAD_WIDTH  zero-extended load data; 0 for stores
d_err  output  1  misaligned data access, valid with d_rvalid
ram_op  output  ram_pkg::ram_op_t  to ram.op
ram_size  output  ram_pkg::ram_size_t  to ram.size
ram_addr  output  ADDRW  to ram.addr
ram_data_in  output  QUAD_WIDTH  to ram.data_in
ram_data_out  input  QUAD_WIDTH  from ram.data_out
busy  output  1  high in S_WAIT

Behaviour:
- Reset (async, rst=1): state S_IDLE; every output 0; ram_op=RAM_NOP; last-winner register = fetch.
- FSM states:
  - S_IDLE: ram_op=RAM_NOP unless a grant is issued this cycle.
  - S_WAIT: ram_op=RAM_NOP always. The ram holds its registered address, so ram_data_out is valid here.
- Eligibility:
  - d_req is eligible only when d_op is RAM_LOAD or RAM_STORE; d_req with RAM_NOP is ignored (no gnt).
  - i_req is always eligible.
- Arbitration (S_IDLE only): data port has fixed priority over fetch.
- Alignment legality:
  - quad: addr[2:0]=0.
  - long: addr[1:0]=0.
  - word: addr[0]=0.
  - byte: always legal.
  - Fetch is always size long.
- Grant cycle (S_IDLE, eligible winner):
  - Pulse that port's gnt combinationally.
  - If aligned: drive ram_op/size/addr/data_in from the winner (fetch: RAM_LOAD, RAM_LONG, d_wdata ignored); next state S_WAIT.
  - If misaligned: ram_op=RAM_NOP; register err response; next state S_IDLE; rvalid+err next cycle, rdata=0.
  - Record owner.
- S_WAIT:
  - Register the owner's response: fetch gets ram_data_out[31:0]; data load gets ram_data_out; store gets 0.
  - Next state S_IDLE.
  - Owner's rvalid pulses in the following cycle (S_IDLE).
- Latency and throughput:
  - Grant at cycle N, rvalid at N+2.
  - A new grant may occur in the same cycle as a previous rvalid.
  - Maximum throughput: one access per 2 cycles.
- Only one rvalid (i or d) is high in any cycle. gnt is never asserted in S_WAIT.
- Simultaneous i_req and d_req: data wins; fetch waits with req held.
- Reset mid-operation: S_WAIT aborts; no rvalid is issued. A store already presented in the grant cycle has been written.
- Requester may change addr/data only after gnt. Dropping req before gnt withdraws the request.

Optional Feature:
RAM_ARB_RR_EN
- Defined: round-robin arbitration; on a conflict, the port that did not win the last grant wins. The last-winner register updates on every grant, including misaligned ones.
- Undefined: fixed data priority as above; last-winner register is absent.

Test Plan:
- Fetch alone: i_req=1, i_addr=0x00104, RAM long at 0x104 = 0xDEADBEEF -> i_gnt at cycle 0, ram_op=RAM_LOAD/RAM_LONG, i_rvalid at cycle 2 with i_rdata=0xDEADBEEF, i_err=0.
- Store then load: d STORE BYTE addr 0x00013 data 0xA5, then d LOAD QUAD addr 0x00010 -> second d_rvalid returns d_rdata[31:24]=0xA5; store d_rvalid has d_rdata=0; grants spaced 2 cycles apart.
- Conflict: i_req and d_req both high at cycle 0 -> d_gnt cycle 0, i_gnt cycle 2 (fixed). With RAM_ARB_RR_EN, repeat the conflict -> grants alternate d, i, d.
- Misaligned: d LOAD LONG addr 0x00006 -> d_gnt, ram_op stays RAM_NOP, next cycle d_rvalid=1, d_err=1, d_rdata=0; state S_IDLE.
- d_req with d_op=RAM_NOP while i_req=1 -> only i_gnt, no d_gnt.
- Reset in S_WAIT: assert rst the cycle after a fetch grant -> i_rvalid never pulses, all outputs 0, busy=0; the next request after reset is served normally.
